pipeline_hazard_controller: RTL and testbench

//   Central stall/flush sequencer for the 5-stage RV32I pipeline.

---
 rtl/pipeline_hazard_controller_if.sv | 50 +++++
 rtl/pipeline_hazard_controller.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_if
// Description : Hazard inputs and stage enable/flush outputs of the pipeline
//               hazard controller, grouped with directional modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_controller_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic              ex_mem_read_i;
    logic [REG_AW-1:0] ex_rd_i;
    logic              ex_redirect_i;
    logic              imem_ready_i;
    logic              dmem_req_i;
    logic              dmem_ready_i;

    logic              pc_write_o;
    logic              if_id_write_o;
    logic              if_id_flush_o;
    logic              id_ex_write_o;
    logic              id_ex_flush_o;
    logic              ex_mem_write_o;
    logic [1:0]        ctrl_state_o;
    logic              dmem_timeout_o;
    logic [CNT_W-1:0]  stall_cycles_o;
    logic [CNT_W-1:0]  redirect_cnt_o;

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_mem_read_i,
               ex_rd_i, ex_redirect_i, imem_ready_i, dmem_req_i, dmem_ready_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o,
               id_ex_flush_o, ex_mem_write_o, ctrl_state_o, dmem_timeout_o,
               stall_cycles_o, redirect_cnt_o
    );

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_mem_read_i,
               ex_rd_i, ex_redirect_i, imem_ready_i, dmem_req_i, dmem_ready_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_write_o,
               id_ex_flush_o, ex_mem_write_o, ctrl_state_o, dmem_timeout_o,
               stall_cycles_o, redirect_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall/flush sequencer for a 5-stage RV32I pipeline with a
//               memory-wait FSM, data-memory watchdog and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 16,
    parameter int DMEM_TIMEOUT = 255
) (
    input  wire logic                  clk_i,
    input  wire logic                  reset_n_i,
    pipeline_hazard_controller_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN            = 2'd0,
        ST_DMEM_WAIT      = 2'd1,
        ST_FETCH_REDIRECT = 2'd2
    } state_e;

    localparam int               WD_W     = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(DMEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] redir_q, redir_d;

    logic w_dstall, w_luse, w_redir_take;
    logic w_pc_w, w_ifid_w, w_ifid_f, w_idex_w, w_idex_f, w_exmem_w;

    assign w_dstall = hz.dmem_req_i & ~hz.dmem_ready_i;
    assign w_luse   = hz.ex_mem_read_i & (hz.ex_rd_i != {REG_AW{1'b0}}) &
                      ((hz.id_use_rs1_i & (hz.id_rs1_i == hz.ex_rd_i)) |
                       (hz.id_use_rs2_i & (hz.id_rs2_i == hz.ex_rd_i)));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_RUN;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            redir_q   <= '0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            redir_q   <= redir_d;
        end
    end

    always_comb begin
        w_pc_w       = 1'b1;
        w_ifid_w     = 1'b1;
        w_ifid_f     = 1'b0;
        w_idex_w     = 1'b1;
        w_idex_f     = 1'b0;
        w_exmem_w    = 1'b1;
        w_redir_take = 1'b0;
        wd_d         = '0;
        state_d      = state_q;

        if (state_q == ST_FETCH_REDIRECT) begin
            // EX holds a bubble here, so redirects and load-use are not possible.
            if (w_dstall) begin
                w_pc_w    = 1'b0;
                w_idex_w  = 1'b0;
                w_exmem_w = 1'b0;
                w_ifid_f  = 1'b1;
            end else if (hz.imem_ready_i) begin
                state_d = ST_RUN;
            end else begin
                w_pc_w   = 1'b0;
                w_ifid_f = 1'b1;
            end
        end else if ((state_q == ST_RUN && w_dstall) ||
                     (state_q == ST_DMEM_WAIT && !hz.dmem_ready_i)) begin
            w_pc_w    = 1'b0;
            w_ifid_w  = 1'b0;
            w_idex_w  = 1'b0;
            w_exmem_w = 1'b0;
            state_d   = ST_DMEM_WAIT;
            if (state_q == ST_DMEM_WAIT)
                wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + WD_W'(1);
        end else begin
            // RUN without a data stall, or the DMEM_WAIT release cycle.
            state_d = ST_RUN;
            if (hz.ex_redirect_i) begin
                w_ifid_f     = 1'b1;
                w_idex_f     = 1'b1;
                w_redir_take = 1'b1;
                if (!hz.imem_ready_i)
                    state_d = ST_FETCH_REDIRECT;
            end else if (w_luse) begin
                w_pc_w   = 1'b0;
                w_ifid_w = 1'b0;
                w_idex_f = 1'b1;
            end else if (!hz.imem_ready_i) begin
                w_pc_w   = 1'b0;
                w_ifid_f = 1'b1;
            end
        end

        timeout_d = timeout_q |
                    ((state_q == ST_DMEM_WAIT) && !hz.dmem_ready_i && (wd_d == WD_LIMIT));
        stall_d   = (!w_pc_w && stall_q != CNT_MAX) ? stall_q + CNT_W'(1) : stall_q;
        redir_d   = (w_redir_take && redir_q != CNT_MAX) ? redir_q + CNT_W'(1) : redir_q;
    end

    assign hz.pc_write_o     = reset_n_i & w_pc_w;
    assign hz.if_id_write_o  = reset_n_i & w_ifid_w;
    assign hz.if_id_flush_o  = reset_n_i & w_ifid_f;
    assign hz.id_ex_write_o  = reset_n_i & w_idex_w;
    assign hz.id_ex_flush_o  = reset_n_i & w_idex_f;
    assign hz.ex_mem_write_o = reset_n_i & w_exmem_w;
    assign hz.ctrl_state_o   = state_q;
    assign hz.dmem_timeout_o = timeout_q;
    assign hz.stall_cycles_o = stall_q;
    assign hz.redirect_cnt_o = redir_q;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed vectors with a queued expected-response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;
    localparam int REG_AW       = 5;
    localparam int CNT_W        = 4;
    localparam int DMEM_TIMEOUT = 8;

    // Write/flush vector order: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w}
    localparam logic [5:0] W_RUN = 6'b110101;
    localparam logic [5:0] W_FRZ = 6'b000000;
    localparam logic [5:0] W_LU  = 6'b000111;
    localparam logic [5:0] W_RD  = 6'b111111;
    localparam logic [5:0] W_IW  = 6'b011101;
    localparam logic [5:0] W_FRD = 6'b011000;
    localparam logic [1:0] S0 = 2'd0, S1 = 2'd1, S2 = 2'd2;

    typedef struct packed {
        logic [4:0] rs1, rs2;
        logic       u1, u2, mr;
        logic [4:0] rd;
        logic       redir, imem, dreq, drdy;
    } stim_t;

    typedef struct {
        logic [5:0]       w;
        logic [1:0]       st;
        logic             to;
        logic [CNT_W-1:0] sc, rc;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipeline_hazard_controller #(
        .REG_AW(REG_AW), .CNT_W(CNT_W), .DMEM_TIMEOUT(DMEM_TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .hz        (bus)
    );

    exp_t             sb[$];
    exp_t             me;
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] m_sc = '0;
    logic [CNT_W-1:0] m_rc = '0;
    stim_t            s;

    function automatic stim_t idle();
        stim_t t;
        t      = '0;
        t.imem = 1'b1;
        return t;
    endfunction

    task automatic drive(input stim_t t);
        bus.id_rs1_i      = t.rs1;
        bus.id_rs2_i      = t.rs2;
        bus.id_use_rs1_i  = t.u1;
        bus.id_use_rs2_i  = t.u2;
        bus.ex_mem_read_i = t.mr;
        bus.ex_rd_i       = t.rd;
        bus.ex_redirect_i = t.redir;
        bus.imem_ready_i  = t.imem;
        bus.dmem_req_i    = t.dreq;
        bus.dmem_ready_i  = t.drdy;
    endtask

    task automatic push(input logic [5:0] w, input logic [1:0] st, input logic to);
        exp_t e;
        e.w  = w;
        e.st = st;
        e.to = to;
        e.sc = m_sc;
        e.rc = m_rc;
        sb.push_back(e);
    endtask

    // One cycle: drive inputs, queue expected outputs, advance counter model.
    task automatic step(input stim_t t, input logic [5:0] w, input logic [1:0] st,
                        input logic to, input logic racc);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(t);
        push(w, st, to);
        if (!w[5] && m_sc != '1) m_sc = m_sc + 1'b1;
        if (racc && m_rc != '1)  m_rc = m_rc + 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive(idle());
        m_sc = '0;
        m_rc = '0;
        push(W_FRZ, S0, 1'b0);
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            me = sb.pop_front();
            chk("writes", 32'({bus.pc_write_o, bus.if_id_write_o, bus.if_id_flush_o,
                               bus.id_ex_write_o, bus.id_ex_flush_o, bus.ex_mem_write_o}),
                32'(me.w));
            chk("ctrl_state",   32'(bus.ctrl_state_o),   32'(me.st));
            chk("dmem_timeout", 32'(bus.dmem_timeout_o), 32'(me.to));
            chk("stall_cycles", 32'(bus.stall_cycles_o), 32'(me.sc));
            chk("redirect_cnt", 32'(bus.redirect_cnt_o), 32'(me.rc));
        end
    end

    initial begin
        drive(idle());
        do_reset();
        step(idle(), W_RUN, S0, 1'b0, 1'b0);

        // Load-use on rs1, then x0 destination, rs2 match, unused operand, non-load
        s = idle(); s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
        step(s, W_LU, S0, 1'b0, 1'b0);
        step(idle(), W_RUN, S0, 1'b0, 1'b0);
        s = idle(); s.mr = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
        step(s, W_RUN, S0, 1'b0, 1'b0);
        s = idle(); s.mr = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1;
        step(s, W_LU, S0, 1'b0, 1'b0);
        s = idle(); s.mr = 1'b1; s.rd = 5'd9; s.rs1 = 5'd9;
        step(s, W_RUN, S0, 1'b0, 1'b0);
        s = idle(); s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
        step(s, W_RUN, S0, 1'b0, 1'b0);

        // Redirect with a stale fetch; a redirect during FETCH_REDIRECT is ignored
        s = idle(); s.redir = 1'b1; s.imem = 1'b0;
        step(s, W_RD, S0, 1'b0, 1'b1);
        s = idle(); s.imem = 1'b0;
        step(s, W_IW, S2, 1'b0, 1'b0);
        s.redir = 1'b1;
        step(s, W_IW, S2, 1'b0, 1'b0);
        s.redir = 1'b0;
        step(s, W_IW, S2, 1'b0, 1'b0);
        step(idle(), W_RUN, S2, 1'b0, 1'b0);
        step(idle(), W_RUN, S0, 1'b0, 1'b0);

        // Redirect with fetch ready, imem wait alone, luse over imem, redirect over luse
        s = idle(); s.redir = 1'b1;
        step(s, W_RD, S0, 1'b0, 1'b1);
        s = idle(); s.imem = 1'b0;
        step(s, W_IW, S0, 1'b0, 1'b0);
        s = idle(); s.imem = 1'b0; s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
        step(s, W_LU, S0, 1'b0, 1'b0);
        s.imem = 1'b1; s.redir = 1'b1;
        step(s, W_RD, S0, 1'b0, 1'b1);

        // Data stall with a pending load-use; bubble issued on release
        s = idle(); s.dreq = 1'b1; s.mr = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
        step(s, W_FRZ, S0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(s, W_FRZ, S1, 1'b0, 1'b0);
        s.drdy = 1'b1;
        step(s, W_LU, S1, 1'b0, 1'b0);
        step(idle(), W_RUN, S0, 1'b0, 1'b0);

        // Redirect concurrent with a data stall is held until release
        s = idle(); s.dreq = 1'b1; s.redir = 1'b1;
        step(s, W_FRZ, S0, 1'b0, 1'b0);
        step(s, W_FRZ, S1, 1'b0, 1'b0);
        s.drdy = 1'b1;
        step(s, W_RD, S1, 1'b0, 1'b1);
        step(idle(), W_RUN, S0, 1'b0, 1'b0);

        // Release-cycle redirect with stale fetch, then a data stall in FETCH_REDIRECT
        s = idle(); s.dreq = 1'b1;
        step(s, W_FRZ, S0, 1'b0, 1'b0);
        s.drdy = 1'b1; s.redir = 1'b1; s.imem = 1'b0;
        step(s, W_RD, S1, 1'b0, 1'b1);
        s = idle(); s.imem = 1'b0; s.dreq = 1'b1;
        step(s, W_FRD, S2, 1'b0, 1'b0);
        step(idle(), W_RUN, S2, 1'b0, 1'b0);
        step(idle(), W_RUN, S0, 1'b0, 1'b0);

        // Release cycle with only an imem wait
        s = idle(); s.dreq = 1'b1;
        step(s, W_FRZ, S0, 1'b0, 1'b0);
        s.drdy = 1'b1; s.imem = 1'b0;
        step(s, W_IW, S1, 1'b0, 1'b0);
        step(idle(), W_RUN, S0, 1'b0, 1'b0);

        // Watchdog: flag after the 8th DMEM_WAIT cycle, then async reset mid-wait
        s = idle(); s.dreq = 1'b1;
        step(s, W_FRZ, S0, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) step(s, W_FRZ, S1, (k >= 9), 1'b0);
        do_reset();
        step(idle(), W_RUN, S0, 1'b0, 1'b0);

        // Stall counter saturation at 2^CNT_W-1
        s = idle(); s.imem = 1'b0;
        for (int i = 0; i < 17; i++) step(s, W_IW, S0, 1'b0, 1'b0);
        step(idle(), W_RUN, S0, 1'b0, 1'b0);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
